// File: rtl/ps_stck_pkg.sv
// Shared parameters, flag bit positions and request decode for the program-sequencer stack.
package ps_stck_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int SP_W   = $clog2(DEPTH) + 1;

  // Bit positions inside the sequencer status register
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_COL = 2;
  localparam int FLG_W   = 3;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } stck_op_e;
endpackage

// File: rtl/ps_stck_rsp_if.sv
// Bus-connect / sequencer handshake bundle seen by the stack.
interface ps_stck_rsp_if #(
  parameter int DATA_W = ps_stck_pkg::DATA_W
);
  logic              ps_pshstck;
  logic              ps_popstck;
  logic [DATA_W-1:0] ps_bc_dt;
  logic              ps_flg_clr;
  logic [DATA_W-1:0] ps_stck_dt;
  logic              ps_stck_vld;
  logic              ps_stck_full;
  logic              ps_stck_empty;
  logic              ps_stck_ovf;
  logic              ps_stck_unf;
  logic              ps_stck_col;

  modport master (
    output ps_pshstck, ps_popstck, ps_bc_dt, ps_flg_clr,
    input  ps_stck_dt, ps_stck_vld, ps_stck_full, ps_stck_empty,
           ps_stck_ovf, ps_stck_unf, ps_stck_col
  );

  modport slave (
    input  ps_pshstck, ps_popstck, ps_bc_dt, ps_flg_clr,
    output ps_stck_dt, ps_stck_vld, ps_stck_full, ps_stck_empty,
           ps_stck_ovf, ps_stck_unf, ps_stck_col
  );
endinterface

// File: rtl/ps_stck_mem.sv
// Stack storage: one synchronous write port, one combinational read port, contents not reset.
module ps_stck_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/ps_stck_rsp.sv
// Program-sequencer stack: SP counter, deferred push write, pop forwarding and sticky flags.
module ps_stck_rsp
  import ps_stck_pkg::*;
#(
  parameter int DATA_W = ps_stck_pkg::DATA_W,
  parameter int DEPTH  = ps_stck_pkg::DEPTH,
  parameter int SP_W   = ps_stck_pkg::SP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  ps_stck_rsp_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic              pend_q, pend_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [DATA_W-1:0] dt_q, dt_d;
  logic              vld_q, vld_d;
  logic [FLG_W-1:0]  flg_q, flg_d, flg_set;

  logic              full, empty, fwd;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  stck_op_e          op;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign rd_addr = AW'(sp_q - SP_W'(1));
  // Push operand is only on the bus now; memory still holds the stale word
  assign fwd     = pend_q && (wptr_q == rd_addr);

  ps_stck_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (pend_q),
    .wr_addr (wptr_q),
    .wr_data (bus.ps_bc_dt),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Pop outranks push, matching sequencer select priority
  always_comb begin
    op = OP_IDLE;
    if (bus.ps_popstck)      op = OP_POP;
    else if (bus.ps_pshstck) op = OP_PUSH;
  end

  always_comb begin
    sp_d    = sp_q;
    pend_d  = 1'b0;
    wptr_d  = wptr_q;
    dt_d    = dt_q;
    vld_d   = 1'b0;
    flg_set = '0;
    case (op)
      OP_POP: begin
        flg_set[FLG_COL] = bus.ps_pshstck;
        if (!empty) begin
          sp_d  = sp_q - SP_W'(1);
          dt_d  = fwd ? bus.ps_bc_dt : rd_data;
          vld_d = 1'b1;
        end else begin
          dt_d             = '0;
          flg_set[FLG_UNF] = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!full) begin
          sp_d   = sp_q + SP_W'(1);
          pend_d = 1'b1;
          wptr_d = sp_q[AW-1:0];
        end else begin
          flg_set[FLG_OVF] = 1'b1;
        end
      end
      default: ;
    endcase
    flg_d = bus.ps_flg_clr ? '0 : (flg_q | flg_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q   <= '0;
      pend_q <= 1'b0;
      wptr_q <= '0;
      dt_q   <= '0;
      vld_q  <= 1'b0;
      flg_q  <= '0;
    end else begin
      sp_q   <= sp_d;
      pend_q <= pend_d;
      wptr_q <= wptr_d;
      dt_q   <= dt_d;
      vld_q  <= vld_d;
      flg_q  <= flg_d;
    end
  end

  assign bus.ps_stck_dt    = dt_q;
  assign bus.ps_stck_vld   = vld_q;
  assign bus.ps_stck_full  = full;
  assign bus.ps_stck_empty = empty;
  assign bus.ps_stck_ovf   = flg_q[FLG_OVF];
  assign bus.ps_stck_unf   = flg_q[FLG_UNF];
  assign bus.ps_stck_col   = flg_q[FLG_COL];
endmodule

// File: tb/tb_ps_stck_rsp.sv
// Scoreboard bench for ps_stck_rsp: a queue-based stack model predicts pops, a monitor checks them.
module tb_ps_stck_rsp;
  localparam int DW  = 16;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps_stck_rsp_if #(.DATA_W(DW)) bus ();

  ps_stck_rsp #(.DATA_W(DW), .DEPTH(DEP), .SP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_stk [$];
  logic [DW-1:0] exp_q [$];
  logic m_ovf = 0, m_unf = 0, m_col = 0;
  logic prev_psh = 0;
  logic [DW-1:0] prev_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("empty", 32'(bus.ps_stck_empty), 32'(m_stk.size() == 0));
    chk("full",  32'(bus.ps_stck_full),  32'(m_stk.size() == DEP));
    chk("ovf",   32'(bus.ps_stck_ovf),   32'(m_ovf));
    chk("unf",   32'(bus.ps_stck_unf),   32'(m_unf));
    chk("col",   32'(bus.ps_stck_col),   32'(m_col));
  endtask

  // One decode cycle: push/pop request, flag clear, and the push operand for next cycle
  task automatic do_cycle(input bit psh, input bit pop, input bit clr, input logic [DW-1:0] pdat);
    bit pop_empty;
    @(negedge clk);
    bus.ps_pshstck = psh;
    bus.ps_popstck = pop;
    bus.ps_flg_clr = clr;
    bus.ps_bc_dt   = prev_psh ? prev_dat : DW'($urandom);
    pop_empty = pop && (m_stk.size() == 0);
    if (clr) begin
      m_ovf = 0; m_unf = 0; m_col = 0;
    end
    if (pop) begin
      if (!clr && psh) m_col = 1;
      if (m_stk.size() > 0) exp_q.push_back(m_stk.pop_back());
      else if (!clr) m_unf = 1;
    end else if (psh) begin
      if (m_stk.size() < DEP) m_stk.push_back(pdat);
      else if (!clr) m_ovf = 1;
    end
    prev_psh = psh;
    prev_dat = pdat;
    @(posedge clk);
    #1;
    chk_status();
    if (pop_empty) begin
      chk("unf_vld", 32'(bus.ps_stck_vld), 32'd0);
      chk("unf_dt",  32'(bus.ps_stck_dt),  32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ps_pshstck = 0; bus.ps_popstck = 0; bus.ps_flg_clr = 0;
    m_stk.delete(); exp_q.delete();
    m_ovf = 0; m_unf = 0; m_col = 0;
    prev_psh = 0;
    @(posedge clk);
    #1;
    chk("rst_dt",  32'(bus.ps_stck_dt),  32'd0);
    chk("rst_vld", 32'(bus.ps_stck_vld), 32'd0);
    chk_status();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every valid pop must match the oldest outstanding expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.ps_stck_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld: got dt=%0h expected no pop", bus.ps_stck_dt);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          chk("pop_dt", 32'(bus.ps_stck_dt), 32'(e));
          $display("pop dt=%04h exp=%04h", bus.ps_stck_dt, e);
        end
      end
    end
  end

  initial begin
    bus.ps_pshstck = 0; bus.ps_popstck = 0; bus.ps_flg_clr = 0; bus.ps_bc_dt = '0;
    do_reset();

    // Reset during the write cycle of a push
    do_cycle(1, 0, 0, 16'h1234);
    @(negedge clk);
    bus.ps_bc_dt = 16'h1234;
    rst_n = 1'b0;
    do_reset();
    idle(1);

    // LIFO order
    do_cycle(1, 0, 0, 16'hAAAA);
    do_cycle(1, 0, 0, 16'hBBBB);
    do_cycle(1, 0, 0, 16'hCCCC);
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, '0);
    idle(1);

    // Push immediately followed by pop uses the bus bypass
    do_cycle(1, 0, 0, 16'h5A5A);
    do_cycle(0, 1, 0, '0);
    idle(1);

    // Fill, overflow, drain
    for (int i = 0; i < DEP; i++) do_cycle(1, 0, 0, DW'(16'h1000 + i));
    do_cycle(1, 0, 0, 16'hDEAD);
    for (int i = 0; i < DEP; i++) do_cycle(0, 1, 0, '0);
    do_cycle(0, 0, 1, '0);

    // Underflow then clear
    do_cycle(0, 1, 0, '0);
    do_cycle(0, 0, 1, '0);

    // Collision with one entry
    do_cycle(1, 0, 0, 16'h7777);
    idle(1);
    do_cycle(1, 1, 0, 16'h9999);
    do_cycle(0, 0, 1, '0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      do_cycle(r < 45, (r >= 40) && (r < 85), $urandom_range(0, 19) == 0, DW'($urandom));
    end
    idle(2);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
